// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing (sync, de, coordinates, strobes, frame count)
module video_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 11,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          sync_clr,
    output logic          p_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_ACT = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_BEG = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_cnt, div_nxt;
    logic [CW-1:0] x_nxt, y_nxt;
    logic [FW-1:0] fc_nxt;
    logic          h_wrap, v_wrap, hs_nxt, vs_nxt;

    // next-state of divider and raster counters; sync_clr overrides everything, en=0 holds
    always_comb begin
        p_tick      = en && !sync_clr && (div_cnt == DIV_LAST);
        h_wrap      = p_tick && (x == H_LAST);
        v_wrap      = h_wrap && (y == V_LAST);
        div_nxt     = sync_clr ? '0 : !en ? div_cnt : p_tick ? '0 : div_cnt + 1'b1;
        x_nxt       = sync_clr ? '0 : h_wrap ? '0 : p_tick ? x + 1'b1 : x;
        y_nxt       = sync_clr ? '0 : v_wrap ? '0 : h_wrap ? y + 1'b1 : y;
        fc_nxt      = v_wrap ? frame_cnt + 1'b1 : frame_cnt;
        hs_nxt      = (x_nxt >= HS_BEG && x_nxt <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vs_nxt      = (y_nxt >= VS_BEG && y_nxt <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
        de          = (x < H_ACT) && (y < V_ACT);
        line_start  = p_tick && (x == '0);
        frame_start = line_start && (y == '0);
    end

    // state registers; syncs follow the next coordinates so they stay aligned with x/y
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            hsync     <= ~HSYNC_POL;
            vsync     <= ~VSYNC_POL;
        end else if (en || sync_clr) begin
            div_cnt   <= div_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            frame_cnt <= fc_nxt;
            hsync     <= hs_nxt;
            vsync     <= vs_nxt;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of a small-raster timing generator and a CLK_DIV=1 twin
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic reset_n, en, sync_clr;
    logic p_tick, hsync, vsync, de, line_start, frame_start;
    logic [4:0] x, y;
    logic [1:0] frame_cnt;
    logic p_tick1, hsync1, vsync1, de1, ls1, fs1;
    logic [4:0] x1, y1;
    logic [1:0] fc1;
    int n_cmp = 0;
    int n_err = 0;
    int k = 0;

    // 15x8 raster (8/2/3/2, 4/1/2/1), 3 clks per pixel, mixed sync polarity
    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(3), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CW(5), .FW(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sync_clr(sync_clr),
        .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    // same raster, one clk per pixel, active-high hsync
    video_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(5), .FW(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .sync_clr(sync_clr),
        .p_tick(p_tick1), .hsync(hsync1), .vsync(vsync1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_to(input int t);
        while (k < t) begin
            step(1);
            k++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b1;
        sync_clr = 1'b0;
        step(3);
        reset_n = 1'b1;
        k = 0;
        #1;
        chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_de", de, 1);
        chk("rst_hs", hsync, 1); chk("rst_vs", vsync, 0); chk("rst_pt", p_tick, 0);
        chk("rst_fc", frame_cnt, 0); chk("rst_ls", line_start, 0);
        chk("d1_pt", p_tick1, 1); chk("d1_x0", x1, 0);
        go_to(2);
        chk("pt_k2", p_tick, 1); chk("ls_k2", line_start, 1); chk("fs_k2", frame_start, 1);
        chk("x_k2", x, 0);
        go_to(3);
        chk("x_k3", x, 1); chk("pt_k3", p_tick, 0); chk("ls_k3", line_start, 0);
        go_to(9);
        chk("d1_x9", x1, 9); chk("d1_hs_off", hsync1, 0);
        go_to(10);
        chk("d1_x10", x1, 10); chk("d1_hs_on", hsync1, 1);
        go_to(15);
        chk("d1_xwrap", x1, 0); chk("d1_y1", y1, 1);
        go_to(23);
        chk("x7", x, 7); chk("de_x7", de, 1);
        go_to(24);
        chk("x8", x, 8); chk("de_x8", de, 0);
        go_to(29);
        chk("x9", x, 9); chk("hs_x9", hsync, 1);
        go_to(30);
        chk("x10", x, 10); chk("hs_x10", hsync, 0);
        go_to(38);
        chk("hs_x12", hsync, 0);
        go_to(39);
        chk("x13", x, 13); chk("hs_x13", hsync, 1);
        go_to(44);
        chk("x14", x, 14); chk("pt_x14", p_tick, 1); chk("ls_x14", line_start, 0);
        go_to(45);
        chk("xwrap", x, 0); chk("yinc", y, 1);
        go_to(47);
        chk("ls_y1", line_start, 1); chk("fs_y1", frame_start, 0);
        go_to(180);
        chk("y4", y, 4); chk("de_y4", de, 0);
        go_to(224);
        chk("vs_y4", vsync, 0);
        go_to(225);
        chk("y5", y, 5); chk("vs_y5", vsync, 1);
        go_to(314);
        chk("vs_y6", vsync, 1);
        go_to(315);
        chk("y7", y, 7); chk("vs_y7", vsync, 0);
        go_to(359);
        chk("fc_pre", frame_cnt, 0); chk("x_last", x, 14); chk("y_last", y, 7);
        chk("pt_last", p_tick, 1);
        go_to(360);
        chk("fc_1", frame_cnt, 1); chk("x_f1", x, 0); chk("y_f1", y, 0);
        chk("fs_f1_div0", frame_start, 0);
        go_to(362);
        chk("fs_f1", frame_start, 1);
        go_to(389);
        chk("frz_x", x, 9); chk("frz_pt", p_tick, 1); chk("frz_hs", hsync, 1);
        en = 1'b0;
        #1;
        chk("frz_pt0", p_tick, 0); chk("frz_d1pt", p_tick1, 0);
        step(7);
        chk("frz_x_hold", x, 9); chk("frz_hs_hold", hsync, 1); chk("frz_pt_hold", p_tick, 0);
        en = 1'b1;
        #1;
        chk("frz_resume_pt", p_tick, 1);
        step(1);
        k = 390;
        chk("frz_x10", x, 10); chk("frz_hs10", hsync, 0); chk("frz_pt10", p_tick, 0);
        go_to(620);
        chk("clr_x", x, 11); chk("clr_y", y, 5); chk("clr_hs", hsync, 0);
        chk("clr_vs", vsync, 1); chk("clr_pt", p_tick, 1); chk("clr_fc", frame_cnt, 1);
        sync_clr = 1'b1;
        #1;
        chk("clr_pt0", p_tick, 0); chk("clr_d1pt", p_tick1, 0);
        step(1);
        sync_clr = 1'b0;
        k = 0;
        chk("clr_x0", x, 0); chk("clr_y0", y, 0); chk("clr_hs_off", hsync, 1);
        chk("clr_vs_off", vsync, 0); chk("clr_fc_hold", frame_cnt, 1); chk("clr_de", de, 1);
        go_to(1);
        chk("clr_pix0_x", x, 0);
        go_to(2);
        chk("clr_fs", frame_start, 1);
        go_to(359);
        chk("wclr_x", x, 14); chk("wclr_y", y, 7); chk("wclr_pt", p_tick, 1);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        k = 0;
        chk("wclr_fc", frame_cnt, 1); chk("wclr_x0", x, 0); chk("wclr_y0", y, 0);
        go_to(360);
        chk("fc_2", frame_cnt, 2);
        go_to(720);
        chk("fc_3", frame_cnt, 3);
        go_to(1080);
        chk("fc_wrap0", frame_cnt, 0);
        go_to(1440);
        chk("fc_wrap1", frame_cnt, 1);
        go_to(1698);
        chk("ar_x", x, 11); chk("ar_y", y, 5); chk("ar_hs", hsync, 0); chk("ar_vs", vsync, 1);
        reset_n = 1'b0;
        #2;
        chk("ar_x0", x, 0); chk("ar_y0", y, 0); chk("ar_fc0", frame_cnt, 0);
        chk("ar_hs1", hsync, 1); chk("ar_vs0", vsync, 0); chk("ar_de", de, 1);
        chk("ar_pt", p_tick, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
